// File: rtl/pixeltyper_pkg.sv
// Shared constants, FSM encoding and glyph-row helper for the text pixel renderers.
package pixeltyper_pkg;

  localparam int CELL_W     = 5;
  localparam int CELL_H     = 5;
  localparam int GLYPH_W    = 4;
  localparam int GLYPH_BITS = 20;
  localparam int NUM_CHARS  = 32;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    DRAW,
    DONE
  } state_t;

  // Row r of a glyph word lives in bits [19-4r:16-4r], MSB is the leftmost column.
  function automatic logic [3:0] glyph_row(input logic [GLYPH_BITS-1:0] bmp,
                                           input logic [2:0] row);
    case (row)
      3'd0:    return bmp[19:16];
      3'd1:    return bmp[15:12];
      3'd2:    return bmp[11:8];
      3'd3:    return bmp[7:4];
      default: return bmp[3:0];
    endcase
  endfunction

endpackage

// File: rtl/text_row_renderer_glyph_rom.sv
// Combinational 4x5 hex-digit font: one 4-bit code in, one 20-bit row-major bitmap out.
module glyph_rom
  import pixeltyper_pkg::*;
(
  input  logic [3:0]            code_i,
  output logic [GLYPH_BITS-1:0] bitmap_o
);

  always_comb begin
    bitmap_o = '0;
    case (code_i)
      4'h0: bitmap_o = 20'hF999F;
      4'h1: bitmap_o = 20'h26227;
      4'h2: bitmap_o = 20'hF1F8F;
      4'h3: bitmap_o = 20'hF171F;
      4'h4: bitmap_o = 20'h99F11;
      4'h5: bitmap_o = 20'hF8F1F;
      4'h6: bitmap_o = 20'hF8F9F;
      4'h7: bitmap_o = 20'hF1244;
      4'h8: bitmap_o = 20'hF9F9F;
      4'h9: bitmap_o = 20'hF9F1F;
      4'hA: bitmap_o = 20'h69F99;
      4'hB: bitmap_o = 20'hE9E9E;
      4'hC: bitmap_o = 20'hF888F;
      4'hD: bitmap_o = 20'hE999E;
      4'hE: bitmap_o = 20'hF8E8F;
      4'hF: bitmap_o = 20'hF8E88;
      default: bitmap_o = '0;
    endcase
  end

endmodule

// File: rtl/text_row_renderer.sv
// Walks the 32-entry character buffer and streams 5x5 glyph cells as pixel plots to the VGA adapter.
module text_row_renderer
  import pixeltyper_pkg::*;
#(
  parameter logic [7:0] X0        = 8'd0,
  parameter logic [6:0] Y0        = 7'd10,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [5:0] char_count,
  input  logic [4:0] cursor_pos,
  input  logic       cursor_en,
  output logic [4:0] ram_address,
  input  logic [3:0] ram_q,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  state_t state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [3:0] code_q, code_d;
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] cur_pos_q, cur_pos_d;
  logic       cur_en_q, cur_en_d;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;

  logic [GLYPH_BITS-1:0] bitmap;
  logic [3:0] row_bits;
  logic       pixel_on;
  logic       cursor_hit;
  logic [2:0] fg, bg;
  logic [7:0] pix_x;
  logic [6:0] pix_y;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    cur_pos_d = cur_pos_q;
    cur_en_d  = cur_en_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = (char_count > 6'(NUM_CHARS)) ? 6'(NUM_CHARS) : char_count;
          cur_pos_d = cursor_pos;
          cur_en_d  = cursor_en;
          idx_d     = '0;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        code_d  = ram_q;
        row_d   = '0;
        col_d   = '0;
        state_d = DRAW;
      end
      DRAW: begin
        if (col_q == 3'(CELL_W - 1)) begin
          col_d = '0;
          if (row_q == 3'(CELL_H - 1)) begin
            if (idx_q == 5'(NUM_CHARS - 1)) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = FETCH;
            end
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          col_d = col_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The pixel for the coming cycle is built from next-state values so the
  // first plot of a cell can use the code arriving on ram_q during LATCH.
  glyph_rom u_glyph_rom (
    .code_i   (code_d),
    .bitmap_o (bitmap)
  );

  always_comb begin
    row_bits   = glyph_row(bitmap, row_d);
    pixel_on   = (col_d < 3'(GLYPH_W)) && ({1'b0, idx_d} < cnt_q) && row_bits[2'd3 - col_d[1:0]];
    cursor_hit = cur_en_q && (idx_d == cur_pos_q);
    fg         = cursor_hit ? BG_COLOUR : FG_COLOUR;
    bg         = cursor_hit ? FG_COLOUR : BG_COLOUR;
    pix_x      = X0 + 8'(idx_d) * 8'(CELL_W) + 8'(col_d);
    pix_y      = Y0 + 7'(row_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      code_q    <= '0;
      cnt_q     <= '0;
      cur_pos_q <= '0;
      cur_en_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      cur_pos_q <= cur_pos_d;
      cur_en_q  <= cur_en_d;
      plot_q    <= (state_d == DRAW);
      if (state_d == DRAW) begin
        x_q      <= pix_x;
        y_q      <= pix_y;
        colour_q <= pixel_on ? fg : bg;
      end
    end
  end

  assign ram_address = idx_q;
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign busy        = (state_q == FETCH) || (state_q == LATCH) || (state_q == DRAW);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_text_row_renderer.sv
// Directed bench for text_row_renderer: a pixel scoreboard filled at each start, drained on every plot.
module tb_text_row_renderer;
  import pixeltyper_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [5:0] char_count = '0;
  logic [4:0] cursor_pos = '0;
  logic       cursor_en = 1'b0;
  logic [4:0] ram_address;
  logic [3:0] ram_q;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  always #5 clk = ~clk;

  // Character buffer model: registered address, unregistered data.
  logic [3:0] mem [NUM_CHARS];
  logic [4:0] addr_r = '0;
  always @(posedge clk) addr_r <= ram_address;
  assign ram_q = mem[addr_r];

  text_row_renderer dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .char_count  (char_count),
    .cursor_pos  (cursor_pos),
    .cursor_en   (cursor_en),
    .ram_address (ram_address),
    .ram_q       (ram_q),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int start_edge = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  int first_cyc = -1;
  int done_cyc = -1;
  logic [7:0]  first_x = '0;
  logic [6:0]  first_y = '0;
  logic [17:0] sb [$];
  logic [2:0]  scr [SCREEN_W][SCREEN_H];
  logic [19:0] font [16];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Every plot cycle pops one expected {x,y,colour}; an empty queue cannot match.
  always @(negedge clk) begin
    int cyc;
    logic [18:0] exp_pix;
    cyc = edge_n - start_edge;
    if (plot === 1'b1) begin
      plot_cnt++;
      if (first_cyc < 0) begin
        first_cyc = cyc;
        first_x = x;
        first_y = y;
      end
      if (int'(x) < SCREEN_W && int'(y) < SCREEN_H) scr[x][y] = colour;
      exp_pix = (sb.size() > 0) ? {1'b1, sb.pop_front()} : 19'd0;
      chk("pixel", {13'd0, 1'b1, x, y, colour}, {13'd0, exp_pix});
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic load_expected(input int cc, input logic ce, input int cp);
    int n;
    logic [3:0] r;
    logic on, hit;
    logic [2:0] c;
    n = (cc > 32) ? 32 : cc;
    sb.delete();
    for (int idx = 0; idx < 32; idx++) begin
      for (int row = 0; row < 5; row++) begin
        r = 4'(font[mem[idx]] >> (16 - 4 * row));
        for (int col = 0; col < 5; col++) begin
          on  = (col < 4) && (idx < n) && r[3 - col];
          hit = ce && (idx == cp);
          c   = (on ^ hit) ? 3'b111 : 3'b000;
          sb.push_back({8'(idx * 5 + col), 7'(10 + row), c});
        end
      end
    end
  endtask

  task automatic kick(input int cc, input logic ce, input int cp);
    plot_cnt = 0;
    done_cnt = 0;
    first_cyc = -1;
    done_cyc = -1;
    load_expected(cc, ce, cp);
    @(negedge clk);
    char_count = 6'(cc);
    cursor_en = ce;
    cursor_pos = 5'(cp);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_edge = edge_n - 1;
    start = 1'b0;
  endtask

  task automatic wait_cycle(input int n);
    while ((edge_n - start_edge) < n) @(negedge clk);
  endtask

  task automatic finish_pass(input string tag);
    for (int i = 0; i < 1000 && done_cnt == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_plots"}, plot_cnt, 800);
    chk({tag, "_dones"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_cyc, 865);
    chk({tag, "_first_plot_cycle"}, first_cyc, 3);
    chk({tag, "_first_xy"}, {first_x, first_y}, {8'd0, 7'd10});
    chk({tag, "_sb_left"}, sb.size(), 0);
    $display("pass %s: plots=%0d dones=%0d done_cycle=%0d first_plot_cycle=%0d",
             tag, plot_cnt, done_cnt, done_cyc, first_cyc);
  endtask

  initial begin
    font = '{20'hF999F, 20'h26227, 20'hF1F8F, 20'hF171F, 20'h99F11, 20'hF8F1F,
             20'hF8F9F, 20'hF1244, 20'hF9F9F, 20'hF9F1F, 20'h69F99, 20'hE9E9E,
             20'hF888F, 20'hE999E, 20'hF8E8F, 20'hF8E88};
    for (int i = 0; i < NUM_CHARS; i++) mem[i] = 4'h8;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {ram_address, x, y, colour, plot, busy, done}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    kick(32, 1'b0, 0);
    finish_pass("all8");
    chk("px_1_11", scr[1][11], 3'b000);
    chk("px_0_11", scr[0][11], 3'b111);

    mem[0] = 4'h1;
    kick(1, 1'b0, 0);
    finish_pass("one");
    for (int yy = 10; yy < 15; yy++) chk("spacing_col_x4", scr[4][yy], 3'b000);
    chk("px_2_10", scr[2][10], 3'b111);
    chk("blank_px_5_10", scr[5][10], 3'b000);

    kick(2, 1'b1, 3);
    finish_pass("cursor");
    chk("cursor_px_15_10", scr[15][10], 3'b111);
    chk("cursor_px_19_14", scr[19][14], 3'b111);
    chk("blank_px_20_10", scr[20][10], 3'b000);

    kick(32, 1'b0, 0);
    wait_cycle(100);
    start = 1'b1;
    char_count = 6'd0;
    cursor_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_pass("busy_start");

    kick(32, 1'b0, 0);
    wait_cycle(400);
    resetn = 1'b0;
    #1;
    chk("abort_plot", plot, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_xy", {x, y}, 15'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    $display("pass abort: plots=%0d before reset", plot_cnt);
    resetn = 1'b1;
    @(negedge clk);
    kick(32, 1'b0, 0);
    finish_pass("restart");

    kick(40, 1'b0, 0);
    finish_pass("count40");

    for (int i = 0; i < NUM_CHARS; i++) mem[i] = 4'($urandom_range(0, 15));
    kick(20, 1'b1, 7);
    finish_pass("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_row_renderer.md
Name: text_row_renderer

Overview:
- Consumes the 32-entry x 4-bit character buffer (ram32x4) and produces per-pixel plot writes for vga_adapter (160x120 logical screen).
- On a start pulse, walks buffer addresses 0..31. For each entry it reads one code, looks up a 4x5 glyph and plots a 5x5 cell: 4 glyph columns plus one background spacing column.
- Sits between the character buffer and the VGA adapter's x/y/colour/plot inputs.

Parameters:
X0, 0, x origin of the text row (pixels)
Y0, 10, y origin of the text row (pixels)
FG_COLOUR, 3'b111, colour for set glyph bits
BG_COLOUR, 3'b000, colour for clear glyph bits and spacing column

Ports:
clk  in  1  system clock (CLOCK_50)
resetn  in  1  async active-low reset
start  in  1  single-cycle request to redraw the whole row
char_count  in  6  number of valid characters (0..32); entries at index >= char_count render blank
cursor_pos  in  5  index of cursor cell
cursor_en  in  1  cursor highlight enable
ram_address  out  5  buffer read address
ram_q  in  4  buffer read data, valid 1 cycle after address is presented (registered address, unregistered q)
x  out  8  pixel x to VGA
y  out  7  pixel y to VGA
colour  out  3  pixel colour to VGA
plot  out  1  pixel write strobe
busy  out  1  high from first FETCH through last DRAW cycle
done  out  1  one-cycle pulse after last pixel

Behaviour:
- Clock: clk. Reset: resetn, asynchronous, active-low.
- Reset values: state=IDLE, ram_address=0, x=0, y=0, colour=0, plot=0, busy=0, done=0, idx=0, row=0, col=0.
- Reset mid-operation aborts immediately: plot drops to 0 and no done pulse is issued.
- FSM states: IDLE, FETCH, LATCH, DRAW, DONE.
- IDLE:
  - start=1 at a clock edge registers char_count, cursor_pos and cursor_en, sets idx=0, and moves to FETCH.
  - start is ignored in every other state.
- FETCH (1 cycle): ram_address=idx, busy=1, plot=0. Next state is LATCH.
- LATCH (1 cycle): ram_q is valid and is registered into code. Next state is DRAW with row=0, col=0.
- DRAW (25 cycles):
  - plot=1.
  - x = X0 + idx*5 + col, truncated to 8 bits.
  - y = Y0 + row, truncated to 7 bits.
  - No clipping.
  - Order is row-major: col 0..4 inside row 0..4.
  - After col=4, row=4:
    - if idx=31, go to DONE;
    - otherwise idx+1 and go to FETCH.
- Colour rule:
  - pixel_on = (col<4) && (idx<char_count) && glyph[code][row][col].
  - If cursor_en && idx==cursor_pos, FG and BG are swapped for the whole cell, including the spacing column and blank cells.
  - colour = pixel_on ? fg : bg.
- DONE (1 cycle): done=1, busy=0, plot=0. Next state is IDLE.
- x, y, colour and plot are registered outputs, asserted together in the same cycle. The VGA adapter samples them on that cycle.
- Timing:
  - 27 cycles per character, 864 cycles from the first FETCH to the last DRAW.
  - done is high in cycle 865 after the start edge.
  - Exactly 800 plot cycles per pass.
- char_count:
  - 0 renders all cells blank.
  - values >32 are treated as 32.
- Glyph format:
  - 20-bit word; row r occupies bits [19-4r:16-4r], MSB = col 0.
  - Codes 0x0..0xF render hex digits 0-F.
  - Example: code 0x8 = rows 1111,1001,1111,1001,1111.
  - Example: code 0x1 = rows 0010,0110,0010,0010,0111.

Decomposition:
- Shared package (pixeltyper_pkg):
  - CELL_W=5, CELL_H=5, GLYPH_W=4, NUM_CHARS=32.
  - FSM state encoding.
  - Screen bounds 160/120.
- One sub-module: glyph_rom. Purely combinational, 4-bit code in, 20-bit bitmap out; shared later by the cursor/score display.

Test Plan:
- Reset, then start with buffer all 0x8, char_count=32, cursor_en=0:
  - first plot at cycle 3 after the start edge with x=0, y=10;
  - pixel (x=1, y=11) is 3'b000 and (x=0, y=11) is 3'b111;
  - exactly 800 plots;
  - done pulses once at cycle 865.
- Buffer[0]=0x1, char_count=1: cell 0 matches the 0x1 bitmap; cells 1..31 are all BG; column x=4 is BG.
- cursor_en=1, cursor_pos=3, char_count=2: cell 3 (x=15..19) is plotted entirely with 3'b111; other blank cells use 3'b000.
- Assert start while busy=1 at cycle 100: ignored, total plot count stays 800, single done pulse.
- resetn low at cycle 400: plot=0, busy=0 and x/y=0 immediately. A new start after release restarts at idx=0 with x=0.
- char_count=40: identical output to char_count=32.
